bit_serializer: RTL and testbench

Parallel-to-serial transmitter: accepts a WIDTH-bit word through a valid/ready handshake and drives it onto a single-bit serial line, one bit per rising clock edge. It is the source for D-flip-flop/shift-register capture stages, so the serial line can be sampled bit-by-bit by a downstream DFF or deserializer. It replaces hand-written bench stimulus with synthesizable, framed bit generation.

---
 rtl/bit_serializer_pkg.sv | 14 +
 rtl/bit_serializer.sv | 68 ++++++
 tb/tb_bit_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state encoding and counter-width helper for bit_serializer
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Counter width for a WIDTH-bit frame; never narrower than one bit.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial transmitter with valid/ready load and framed serial output
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_n,
    output logic             sout_valid,
    output logic             done
);

    localparam int               CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [CNT_W-1:0] r_cnt;

    logic w_shifting;
    logic w_last;
    logic w_accept;
    logic w_bit;

    assign w_shifting = (r_state == SHIFT);
    assign w_last     = w_shifting && (r_cnt == LAST);
    // Accepting during the last bit lets frames run back to back without a gap.
    assign load_ready = !w_shifting || w_last;
    assign w_accept   = load_valid && load_ready;
    assign w_bit      = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

    assign sout       = w_shifting & w_bit;
    assign sout_n     = ~sout;
    assign sout_valid = w_shifting;
    assign done       = w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_state <= SHIFT;
            r_sreg  <= din;
            r_cnt   <= '0;
        end else if (w_shifting) begin
            if (w_last) begin
                r_state <= IDLE;
                r_sreg  <= '0;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                if (LSB_FIRST) begin
                    r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
                end else begin
                    r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer (LSB-first and MSB-first instances)
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         load_valid = 1'b0;

    logic ready_l, sout_l, soutn_l, valid_l, done_l;
    logic ready_m, sout_m, soutn_m, valid_m, done_m;
    logic r_q = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(ready_l),
        .sout(sout_l), .sout_n(soutn_l), .sout_valid(valid_l), .done(done_l)
    );

    bit_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(ready_m),
        .sout(sout_m), .sout_n(soutn_m), .sout_valid(valid_m), .done(done_m)
    );

    // Downstream capture flop on the MSB-first line
    always @(posedge clk) r_q <= sout_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of bits still to appear on each line, front = current bit
    bit ql[$];
    bit qm[$];
    bit started = 1'b0;
    int edges_since_start = 0;
    bit exp_q = 1'b0;

    always @(posedge clk) begin
        bit acc;
        exp_q = (qm.size() > 0) ? qm[0] : 1'b0;
        if (started) edges_since_start++;
        if (rst) begin
            ql.delete();
            qm.delete();
            started = 1'b1;
        end else begin
            acc = load_valid && (ql.size() <= 1);
            if (ql.size() > 0) begin
                void'(ql.pop_front());
                void'(qm.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    ql.push_back(din[i]);
                    qm.push_back(din[W-1-i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic el, em;
        logic [4:0] exp_l, exp_m;
        if (started) begin
            el = (ql.size() > 0) ? ql[0] : 1'b0;
            em = (qm.size() > 0) ? qm[0] : 1'b0;
            exp_l = {el, ~el, ql.size() > 0, ql.size() == 1, ql.size() <= 1};
            exp_m = {em, ~em, qm.size() > 0, qm.size() == 1, qm.size() <= 1};
            chk("model_lsb", {27'd0, sout_l, soutn_l, valid_l, done_l, ready_l}, {27'd0, exp_l});
            chk("model_msb", {27'd0, sout_m, soutn_m, valid_m, done_m, ready_m}, {27'd0, exp_m});
            if (edges_since_start >= 2) chk("loopback_q", {31'd0, r_q}, {31'd0, exp_q});
        end
    end

    // Present a word and hold load_valid until the handshake edge
    task automatic send(input logic [W-1:0] w);
        bit ok = 1'b0;
        din = w;
        load_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (ready_l) ok = 1'b1;
        end
        chk("send_handshake", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    // Collect one frame from both lines, assembled in transmit order
    task automatic collect(output logic [W-1:0] wl, output logic [W-1:0] wm, output logic [W-1:0] dmask);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            wl[i]       = sout_l;
            wm[W-1-i]   = sout_m;
            dmask[i]    = done_l;
        end
    endtask

    initial begin
        logic [W-1:0] wl, wm, dm;
        logic [15:0]  bits, dmask16, rmask16;
        int           nvalid;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_lsb", {27'd0, sout_l, soutn_l, valid_l, done_l, ready_l}, 32'b01001);
        chk("reset_msb", {27'd0, sout_m, soutn_m, valid_m, done_m, ready_m}, 32'b01001);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single frame A5 on both bit orders
        send(8'hA5);
        collect(wl, wm, dm);
        chk("single_lsb_bits", {24'd0, wl}, 32'hA5);
        chk("single_msb_bits", {24'd0, wm}, 32'hA5);
        chk("single_done_pos", {24'd0, dm}, 32'h80);
        @(negedge clk);
        chk("single_idle_after", {30'd0, valid_l, load_ready_idle(ready_l)}, 32'b01);

        // Back-to-back FF then 00 with load_valid held
        @(posedge clk);
        #1 din = 8'hFF; load_valid = 1'b1;
        @(posedge clk);
        #1 din = 8'h00;
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bits[i]    = sout_l;
            dmask16[i] = done_l;
            rmask16[i] = ready_l;
            if (valid_l) nvalid++;
            if (i == 7) begin
                @(posedge clk);
                #1 load_valid = 1'b0;
            end
        end
        chk("b2b_valid_cycles", nvalid, 16);
        chk("b2b_bits", {16'd0, bits}, 32'h00FF);
        chk("b2b_done_mask", {16'd0, dmask16}, 32'h8080);
        chk("b2b_ready_mask", {16'd0, rmask16}, 32'h8080);
        @(negedge clk);
        chk("b2b_idle_after", {31'd0, valid_l}, 32'd0);

        // Backpressure: 3C offered during third bit of A5
        send(8'hA5);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            wl[i] = sout_l;
            dm[i] = done_l;
            if (i == 2) begin
                din = 8'h3C;
                load_valid = 1'b1;
                chk("bp_not_ready", {31'd0, ready_l}, 32'd0);
            end
        end
        @(posedge clk);
        #1 load_valid = 1'b0;
        chk("bp_first_bits", {24'd0, wl}, 32'hA5);
        chk("bp_first_done", {24'd0, dm}, 32'h80);
        collect(wl, wm, dm);
        chk("bp_second_lsb", {24'd0, wl}, 32'h3C);
        chk("bp_second_msb", {24'd0, wm}, 32'h3C);

        // Mid-frame reset at the fourth bit of A5
        @(negedge clk);
        send(8'hA5);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_abort", {29'd0, valid_l, done_l, ready_l}, 32'b001);
        dm = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dm[i] = done_l | valid_l;
        end
        chk("rst_quiet", {24'd0, dm}, 32'h0);
        send(8'h5A);
        collect(wl, wm, dm);
        chk("rst_new_lsb", {24'd0, wl}, 32'h5A);
        chk("rst_new_msb", {24'd0, wm}, 32'h5A);
        chk("rst_new_done", {24'd0, dm}, 32'h80);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic load_ready_idle(input logic r);
        return r;
    endfunction

endmodule
